control_unit: RTL and testbench

- Microprogrammed-style Moore FSM sequencing the multicycle SPARC-subset datapath: fetch, decode, execute, PC/NPC update.
- Drives every register load, mux select, memory strobe and the ALU opcode.
- Reads the instruction register, memory-complete (moc) and the condition-checker result (cond).

---
 rtl/cu_pkg.sv | 87 ++++++++
 rtl/cu_decode.sv | 112 +++++++++++
 rtl/control_unit.sv | 127 ++++++++++++
 tb/tb_control_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: state encodings, ALU opcodes, instruction field constants and the
// control-word layout shared by the control unit and its decoder.
package cu_pkg;

  localparam int CU_STATE_W = 5;

  localparam logic [CU_STATE_W-1:0] S_RESET     = 5'd0;
  localparam logic [CU_STATE_W-1:0] S_FETCH0    = 5'd1;
  localparam logic [CU_STATE_W-1:0] S_FETCH1    = 5'd2;
  localparam logic [CU_STATE_W-1:0] S_DECODE    = 5'd3;
  localparam logic [CU_STATE_W-1:0] S_ARITH     = 5'd4;
  localparam logic [CU_STATE_W-1:0] S_ADDR      = 5'd5;
  localparam logic [CU_STATE_W-1:0] S_LD_MEM    = 5'd6;
  localparam logic [CU_STATE_W-1:0] S_LD_WB     = 5'd7;
  localparam logic [CU_STATE_W-1:0] S_ST_DATA   = 5'd8;
  localparam logic [CU_STATE_W-1:0] S_ST_MEM    = 5'd9;
  localparam logic [CU_STATE_W-1:0] S_BR_TEST   = 5'd10;
  localparam logic [CU_STATE_W-1:0] S_BR_TAKEN  = 5'd11;
  localparam logic [CU_STATE_W-1:0] S_CALL_LINK = 5'd12;
  localparam logic [CU_STATE_W-1:0] S_CALL_JUMP = 5'd13;
  localparam logic [CU_STATE_W-1:0] S_SETHI     = 5'd14;
  localparam logic [CU_STATE_W-1:0] S_JMPL_LINK = 5'd15;
  localparam logic [CU_STATE_W-1:0] S_JMPL_JUMP = 5'd16;
`ifdef CU_ANNUL_EN
  localparam logic [CU_STATE_W-1:0] S_ANNUL     = 5'd17;
`endif
  localparam logic [CU_STATE_W-1:0] S_INIT      = 5'd19;
  localparam logic [CU_STATE_W-1:0] S_PC_UPD    = 5'd20;

  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_ZERO   = 6'b111000;
  localparam logic [5:0] ALU_PASSB  = 6'b111001;
  localparam logic [5:0] ALU_INC4   = 6'b111010;
  localparam logic [5:0] ALU_DISP22 = 6'b111011;
  localparam logic [5:0] ALU_DISP30 = 6'b111100;
  localparam logic [5:0] ALU_SETHI  = 6'b111101;

  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_CALL   = 2'b01;
  localparam logic [1:0] OP_ARITH  = 2'b10;
  localparam logic [1:0] OP_MEM    = 2'b11;
  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;
  localparam logic [5:0] OP3_JMPL  = 6'b111000;

  typedef struct packed {
    logic       mov;
    logic       rw;
    logic       marld;
    logic       mdrld;
    logic       irld;
    logic       pcld;
    logic       npcld;
    logic       rfld;
    logic       frld;
    logic       cin;
    logic       muxa;
    logic [1:0] muxb;
    logic       muxc;
    logic [1:0] muxd;
    logic       muxe;
    logic       muxf;
    logic       muxg;
    logic       muxh;
    logic       muxi;
    logic [5:0] op;
  } ctl_word_t;

  // op2 occupies the top three bits of the op3 field position (ir[24:22]).
  function automatic logic [CU_STATE_W-1:0] decode_target(input logic [1:0] f_op,
                                                          input logic [5:0] f_op3);
    logic [CU_STATE_W-1:0] tgt;
    tgt = S_PC_UPD;
    case (f_op)
      OP_ARITH: tgt = (f_op3 == OP3_JMPL) ? S_JMPL_LINK : S_ARITH;
      OP_MEM:   tgt = S_ADDR;
      OP_CALL:  tgt = S_CALL_LINK;
      default: begin
        if (f_op3[5:3] == OP2_BICC)       tgt = S_BR_TEST;
        else if (f_op3[5:3] == OP2_SETHI) tgt = S_SETHI;
        else                              tgt = S_PC_UPD;
      end
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational present-state to control-word decode (Moore outputs).
// With CU_ANNUL_EN defined, state 17 decodes as a PC/NPC advance.
module cu_decode
  import cu_pkg::*;
(
  input  logic [CU_STATE_W-1:0] i_state,
  input  logic                  i_imm,
  input  logic                  i_setcc,
  output ctl_word_t             o_ctl
);

  logic [1:0] w_b_src;
  assign w_b_src = i_imm ? 2'd1 : 2'd0;

  always_comb begin
    o_ctl = '0;
    case (i_state)
      S_RESET: begin
        o_ctl.op   = ALU_ZERO;
        o_ctl.pcld = 1'b1;
      end
      S_INIT: begin
        o_ctl.muxb  = 2'd3;
        o_ctl.op    = ALU_INC4;
        o_ctl.npcld = 1'b1;
      end
      S_FETCH0: begin
        o_ctl.muxh  = 1'b1;
        o_ctl.marld = 1'b1;
      end
      S_FETCH1: begin
        o_ctl.mov  = 1'b1;
        o_ctl.rw   = 1'b1;
        o_ctl.irld = 1'b1;
      end
      S_ARITH: begin
        o_ctl.muxb = w_b_src;
        o_ctl.muxc = 1'b1;
        o_ctl.rfld = 1'b1;
        o_ctl.frld = i_setcc;
      end
      S_ADDR: begin
        o_ctl.muxb  = w_b_src;
        o_ctl.op    = ALU_ADD;
        o_ctl.marld = 1'b1;
      end
      S_LD_MEM: begin
        o_ctl.mov   = 1'b1;
        o_ctl.rw    = 1'b1;
        o_ctl.mdrld = 1'b1;
      end
      S_LD_WB: begin
        o_ctl.muxb = 2'd2;
        o_ctl.op   = ALU_PASSB;
        o_ctl.rfld = 1'b1;
      end
      S_ST_DATA: begin
        o_ctl.op    = ALU_PASSB;
        o_ctl.muxa  = 1'b1;
        o_ctl.mdrld = 1'b1;
      end
      S_ST_MEM: begin
        o_ctl.mov = 1'b1;
      end
      S_BR_TAKEN, S_CALL_JUMP: begin
        o_ctl.muxe  = 1'b1;
        o_ctl.pcld  = 1'b1;
        o_ctl.muxf  = 1'b1;
        o_ctl.muxb  = 2'd3;
        o_ctl.op    = (i_state == S_BR_TAKEN) ? ALU_DISP22 : ALU_DISP30;
        o_ctl.npcld = 1'b1;
      end
      S_CALL_LINK: begin
        o_ctl.muxg = 1'b1;
        o_ctl.muxb = 2'd3;
        o_ctl.op   = ALU_PASSB;
        o_ctl.rfld = 1'b1;
      end
      S_SETHI: begin
        o_ctl.muxf = 1'b1;
        o_ctl.op   = ALU_SETHI;
        o_ctl.rfld = 1'b1;
      end
      S_JMPL_LINK: begin
        o_ctl.muxb = 2'd3;
        o_ctl.op   = ALU_PASSB;
        o_ctl.rfld = 1'b1;
      end
      S_JMPL_JUMP: begin
        o_ctl.muxe  = 1'b1;
        o_ctl.pcld  = 1'b1;
        o_ctl.muxb  = w_b_src;
        o_ctl.op    = ALU_ADD;
        o_ctl.npcld = 1'b1;
      end
`ifdef CU_ANNUL_EN
      S_PC_UPD, S_ANNUL: begin
`else
      S_PC_UPD: begin
`endif
        o_ctl.muxe  = 1'b1;
        o_ctl.pcld  = 1'b1;
        o_ctl.muxb  = 2'd3;
        o_ctl.muxd  = 2'd1;
        o_ctl.op    = ALU_INC4;
        o_ctl.npcld = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing fetch/decode/execute/PC-update for the
// multicycle SPARC-subset datapath. Macro CU_ANNUL_EN enables annulled branches.
module control_unit
  import cu_pkg::*;
#(
  parameter int STATE_W = CU_STATE_W
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               moc,
  input  logic               en,
  input  logic               cond,
  input  logic               fr_n,
  input  logic               fr_z,
  input  logic               fr_c,
  input  logic               fr_v,
  input  logic [31:0]        ir,
  output logic [STATE_W-1:0] present_state,
  output logic               mov,
  output logic               rw,
  output logic               marld,
  output logic               mdrld,
  output logic               irld,
  output logic               pcld,
  output logic               npcld,
  output logic               rfld,
  output logic               frld,
  output logic               cin,
  output logic               muxa,
  output logic               muxc,
  output logic               muxe,
  output logic               muxf,
  output logic               muxg,
  output logic               muxh,
  output logic               muxi,
  output logic               muxb1,
  output logic               muxb0,
  output logic               muxd1,
  output logic               muxd0,
  output logic               op5,
  output logic               op4,
  output logic               op3,
  output logic               op2,
  output logic               op1,
  output logic               op0
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;
  ctl_word_t          w_ctl;
  logic               w_unused;

  // Flags are part of the datapath interface only; fold them away for lint.
  assign w_unused = ^{fr_n, fr_z, fr_c, fr_v, ir};

  always_comb begin
    w_state_next = r_state;
    if (en) begin
      case (r_state)
        S_RESET:     w_state_next = S_INIT;
        S_INIT:      w_state_next = S_FETCH0;
        S_FETCH0:    w_state_next = S_FETCH1;
        S_FETCH1:    if (moc) w_state_next = S_DECODE;
        S_DECODE:    w_state_next = decode_target(ir[31:30], ir[24:19]);
        S_ARITH:     w_state_next = S_PC_UPD;
        S_ADDR:      w_state_next = ir[21] ? S_ST_DATA : S_LD_MEM;
        S_LD_MEM:    if (moc) w_state_next = S_LD_WB;
        S_LD_WB:     w_state_next = S_PC_UPD;
        S_ST_DATA:   w_state_next = S_ST_MEM;
        S_ST_MEM:    if (moc) w_state_next = S_PC_UPD;
        S_BR_TEST: begin
          w_state_next = S_PC_UPD;
`ifdef CU_ANNUL_EN
          if (ir[29]) w_state_next = S_ANNUL;
`endif
          if (cond) w_state_next = S_BR_TAKEN;
        end
        S_BR_TAKEN:  w_state_next = S_FETCH0;
        S_CALL_LINK: w_state_next = S_CALL_JUMP;
        S_CALL_JUMP: w_state_next = S_FETCH0;
        S_SETHI:     w_state_next = S_PC_UPD;
        S_JMPL_LINK: w_state_next = S_JMPL_JUMP;
        S_JMPL_JUMP: w_state_next = S_FETCH0;
`ifdef CU_ANNUL_EN
        S_ANNUL:     w_state_next = S_PC_UPD;
`endif
        S_PC_UPD:    w_state_next = S_FETCH0;
        default:     w_state_next = S_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_RESET;
    else      r_state <= w_state_next;
  end

  cu_decode u_decode (
    .i_state (r_state),
    .i_imm   (ir[13]),
    .i_setcc (ir[23]),
    .o_ctl   (w_ctl)
  );

  assign present_state = r_state;
  assign mov   = w_ctl.mov;
  assign rw    = w_ctl.rw;
  assign marld = w_ctl.marld;
  assign mdrld = w_ctl.mdrld;
  assign irld  = w_ctl.irld;
  assign pcld  = w_ctl.pcld;
  assign npcld = w_ctl.npcld;
  assign rfld  = w_ctl.rfld;
  assign frld  = w_ctl.frld;
  assign cin   = w_ctl.cin;
  assign muxa  = w_ctl.muxa;
  assign muxc  = w_ctl.muxc;
  assign muxe  = w_ctl.muxe;
  assign muxf  = w_ctl.muxf;
  assign muxg  = w_ctl.muxg;
  assign muxh  = w_ctl.muxh;
  assign muxi  = w_ctl.muxi;
  assign {muxb1, muxb0} = w_ctl.muxb;
  assign {muxd1, muxd0} = w_ctl.muxd;
  assign {op5, op4, op3, op2, op1, op0} = w_ctl.op;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: per-instruction expected state traces plus a spec-table
// model of the control word, checked every cycle. Honours CU_ANNUL_EN.
module tb_control_unit;

  logic clk = 1'b0;
  logic clr, moc, en, cond, fr_n, fr_z, fr_c, fr_v;
  logic [31:0] ir;
  logic [4:0] present_state;
  logic mov, rw, marld, mdrld, irld, pcld, npcld, rfld, frld, cin;
  logic muxa, muxc, muxe, muxf, muxg, muxh, muxi, muxb1, muxb0, muxd1, muxd0;
  logic op5, op4, op3, op2, op1, op0;

  control_unit dut (
    .clk(clk), .clr(clr), .moc(moc), .en(en), .cond(cond),
    .fr_n(fr_n), .fr_z(fr_z), .fr_c(fr_c), .fr_v(fr_v), .ir(ir),
    .present_state(present_state),
    .mov(mov), .rw(rw), .marld(marld), .mdrld(mdrld), .irld(irld),
    .pcld(pcld), .npcld(npcld), .rfld(rfld), .frld(frld), .cin(cin),
    .muxa(muxa), .muxc(muxc), .muxe(muxe), .muxf(muxf), .muxg(muxg),
    .muxh(muxh), .muxi(muxi), .muxb1(muxb1), .muxb0(muxb0),
    .muxd1(muxd1), .muxd0(muxd0),
    .op5(op5), .op4(op4), .op3(op3), .op2(op2), .op1(op1), .op0(op0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mov, rw, marld, mdrld, irld, pcld, npcld, rfld, frld, cin, muxa;
    logic [1:0] muxb;
    logic muxc;
    logic [1:0] muxd;
    logic muxe, muxf, muxg, muxh, muxi;
    logic [5:0] op;
  } cw_t;

  typedef struct {
    int st;
    bit m;
    bit e;
  } step_t;

  int total = 0;
  int bad = 0;
  int exp_state = 0;
  bit chk = 1'b0;
  int n_irld = 0;
  step_t seq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (expected state %0d, t=%0t)",
               name, got, want, exp_state, $time);
    end
  endtask

  // Control word straight from the per-state action list; unlisted outputs 0.
  function automatic cw_t model(input int st, input logic [31:0] i);
    cw_t c;
    logic [1:0] b_src;
    c = '0;
    b_src = i[13] ? 2'd1 : 2'd0;
    case (st)
      0:  begin c.op = 6'b111000; c.pcld = 1; end
      19: begin c.muxb = 3; c.muxd = 0; c.op = 6'b111010; c.npcld = 1; end
      1:  begin c.muxh = 1; c.marld = 1; end
      2:  begin c.mov = 1; c.rw = 1; c.irld = 1; end
      4:  begin c.muxb = b_src; c.muxc = 1; c.rfld = 1; c.frld = i[23]; end
      5:  begin c.muxb = b_src; c.op = 6'b000000; c.marld = 1; end
      6:  begin c.mov = 1; c.rw = 1; c.mdrld = 1; end
      7:  begin c.muxb = 2; c.op = 6'b111001; c.rfld = 1; end
      8:  begin c.muxb = 0; c.op = 6'b111001; c.muxa = 1; c.mdrld = 1; end
      9:  begin c.mov = 1; end
      11: begin c.muxe = 1; c.pcld = 1; c.muxf = 1; c.muxb = 3; c.op = 6'b111011; c.npcld = 1; end
      12: begin c.muxg = 1; c.muxb = 3; c.op = 6'b111001; c.rfld = 1; end
      13: begin c.muxe = 1; c.pcld = 1; c.muxf = 1; c.muxb = 3; c.op = 6'b111100; c.npcld = 1; end
      14: begin c.muxf = 1; c.op = 6'b111101; c.rfld = 1; end
      15: begin c.muxb = 3; c.op = 6'b111001; c.rfld = 1; end
      16: begin c.muxe = 1; c.pcld = 1; c.muxb = b_src; c.op = 6'b000000; c.npcld = 1; end
`ifdef CU_ANNUL_EN
      17: begin c.muxe = 1; c.pcld = 1; c.muxb = 3; c.muxd = 1; c.op = 6'b111010; c.npcld = 1; end
`endif
      20: begin c.muxe = 1; c.pcld = 1; c.muxb = 3; c.muxd = 1; c.op = 6'b111010; c.npcld = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Single compare process: DUT against the model plus a few literal pins.
  always @(negedge clk) begin
    cw_t got, want;
    if (chk) begin
      got = {mov, rw, marld, mdrld, irld, pcld, npcld, rfld, frld, cin, muxa,
             muxb1, muxb0, muxc, muxd1, muxd0, muxe, muxf, muxg, muxh, muxi,
             op5, op4, op3, op2, op1, op0};
      want = model(exp_state, ir);
      check("state", 32'(present_state), exp_state);
      check("ctl", {5'b0, got}, {5'b0, want});
      if (irld) n_irld++;
      if (exp_state == 4 && ir == 32'h86004002)
        check("add_arith", 32'({muxc, muxb1, muxb0, rfld, frld}), 32'(5'b1_00_1_0));
      if (exp_state == 5 && ir == 32'hC4006008)
        check("ld_addr", 32'({marld, op5, op4, op3, op2, op1, op0}), 32'(7'b1_000000));
      if (exp_state == 7)
        check("ld_wb", 32'({muxb1, muxb0, rfld}), 32'(3'b10_1));
      if (exp_state == 11)
        check("br_taken", 32'({pcld, npcld, muxe, op5, op4, op3, op2, op1, op0}), 32'(9'b111_111011));
      if (exp_state == 12)
        check("call_link", 32'({muxg, rfld}), 32'(2'b11));
      if (exp_state == 13)
        check("call_jump", 32'({op5, op4, op3, op2, op1, op0}), 32'(6'b111100));
    end
  end

  task automatic add_step(input int st, input bit m, input bit e);
    step_t s;
    s.st = st; s.m = m; s.e = e;
    seq.push_back(s);
  endtask

  // Wait state: moc low for w cycles, then high on the completing cycle.
  task automatic add_wait(input int st, input int w);
    for (int i = 0; i <= w; i++) add_step(st, i == w, 1'b1);
  endtask

  task automatic play();
    foreach (seq[k]) begin
      exp_state = seq[k].st;
      moc = seq[k].m;
      en = seq[k].e;
      chk = 1'b1;
      @(posedge clk);
      #2;
    end
    seq.delete();
  endtask

  // Instruction class from its SPARC fields, expanded to the visited states.
  task automatic run_instr(input logic [31:0] instr, input bit c, input int fw,
                           input int mw, input int frz);
    bit annul;
    ir = instr;
    cond = c;
`ifdef CU_ANNUL_EN
    annul = instr[29];
`else
    annul = 1'b0;
`endif
    add_step(1, 1'b1, 1'b1);
    add_wait(2, fw);
    for (int i = 0; i < frz; i++) add_step(3, 1'b1, 1'b0);
    add_step(3, 1'b1, 1'b1);
    case (instr[31:30])
      2'b10: begin
        if (instr[24:19] == 6'b111000) begin add_step(15, 1, 1); add_step(16, 1, 1); end
        else begin add_step(4, 1, 1); add_step(20, 1, 1); end
      end
      2'b11: begin
        add_step(5, 1, 1);
        if (instr[21]) begin add_step(8, 1, 1); add_wait(9, mw); end
        else begin add_wait(6, mw); add_step(7, 1, 1); end
        add_step(20, 1, 1);
      end
      2'b01: begin add_step(12, 1, 1); add_step(13, 1, 1); end
      default: begin
        if (instr[24:22] == 3'b010) begin
          add_step(10, 1, 1);
          if (c) add_step(11, 1, 1);
          else begin
            if (annul) add_step(17, 1, 1);
            add_step(20, 1, 1);
          end
        end else if (instr[24:22] == 3'b100) begin
          add_step(14, 1, 1); add_step(20, 1, 1);
        end else begin
          add_step(20, 1, 1);
        end
      end
    endcase
    $display("instr ir=%08h cond=%0b cycles=%0d", instr, c, seq.size());
    play();
  endtask

  initial begin
    clr = 1'b1; moc = 1'b0; en = 1'b1; cond = 1'b0; ir = 32'h0;
    fr_n = 1'b0; fr_z = 1'b1; fr_c = 1'b0; fr_v = 1'b1;
    #1 clr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", 32'(present_state), 32'd0);
    check("reset_pcld_op", 32'({pcld, op5, op4, op3, op2, op1, op0}), 32'(7'b1_111000));
    clr = 1'b1;
    add_step(0, 1'b1, 1'b1);
    add_step(19, 1'b1, 1'b1);

    run_instr(32'h86004002, 1'b0, 0, 0, 2);   // add r1,r2,r3 with en frozen in DECODE
    n_irld = 0;
    run_instr(32'h86004002, 1'b0, 3, 0, 0);   // moc late by 3 cycles
    check("fetch1_hold_cycles", n_irld, 4);
    run_instr(32'h86806005, 1'b0, 0, 0, 0);   // addcc r1,5,r3
    run_instr(32'hC4006008, 1'b0, 1, 2, 0);   // ld [r1+8],r2
    run_instr(32'hC4206008, 1'b0, 0, 1, 0);   // st r2,[r1+8]
    run_instr(32'h02800004, 1'b1, 0, 0, 0);   // be taken
    run_instr(32'h02800004, 1'b0, 0, 0, 0);   // be untaken
    run_instr(32'h22800004, 1'b0, 0, 0, 0);   // be,a untaken
    run_instr(32'h22800004, 1'b1, 0, 0, 0);   // be,a taken
    run_instr(32'h40000010, 1'b0, 0, 0, 0);   // call
    run_instr(32'h05000010, 1'b0, 0, 0, 0);   // sethi
    run_instr(32'h81C3E008, 1'b0, 0, 0, 0);   // jmpl %o7+8,%g0
    run_instr(32'h00000000, 1'b0, 0, 0, 0);   // unimp -> PC update only

    // Asynchronous clear in the middle of a fetch wait.
    ir = 32'h86004002;
    add_step(1, 1'b1, 1'b1);
    add_step(2, 1'b0, 1'b1);
    add_step(2, 1'b0, 1'b1);
    play();
    chk = 1'b0;
    #1 clr = 1'b0;
    #1;
    check("async_clr_state", 32'(present_state), 32'd0);
    check("async_clr_mov", 32'({mov, rw, irld}), 32'd0);
    @(posedge clk);
    #2;
    clr = 1'b1;
    add_step(0, 1'b1, 1'b1);
    add_step(19, 1'b1, 1'b1);
    run_instr(32'h86004002, 1'b0, 0, 0, 0);
    add_step(1, 1'b1, 1'b1);
    play();
    chk = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
